// File: rtl/gpu_wb_pkg.sv
// gpu_wb_pkg: shared register-file constants and writeback source select type.
package gpu_wb_pkg;
  localparam int NUM_REGS    = 16;
  localparam int REG_RO_BASE = 13;
  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_LSU} wb_src_e;
  function automatic logic is_ro(input logic [3:0] rd);
    return rd >= 4'(REG_RO_BASE);
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: load-return buffer, power-of-two depth, async active-low reset of pointers.
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;
  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign rdata   = mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wdata;
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: ALU/load-return write arbitration with optional load scoreboard.
// Define WB_SCOREBOARD_EN to build the pending-register scoreboard and hazard output.
module reg_writeback
  import gpu_wb_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int DATA_BITS         = 8,
  parameter int LSU_FIFO_DEPTH    = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   enable,
  input  logic                                   alu_valid,
  input  logic [3:0]                             alu_rd,
  input  logic [THREADS_PER_BLOCK*DATA_BITS-1:0] alu_data,
  input  logic                                   lsu_valid,
  output logic                                   lsu_ready,
  input  logic [3:0]                             lsu_rd,
  input  logic [THREADS_PER_BLOCK*DATA_BITS-1:0] lsu_data,
  input  logic                                   issue_load_valid,
  input  logic [3:0]                             issue_load_rd,
  input  logic [3:0]                             check_rs,
  input  logic [3:0]                             check_rt,
  input  logic [3:0]                             check_rd,
  output logic                                   hazard,
  output logic                                   decoded_reg_write_enable,
  output logic [3:0]                             decoded_rd_address,
  output logic [THREADS_PER_BLOCK*DATA_BITS-1:0] reg_write_data
);
  localparam int LW = THREADS_PER_BLOCK*DATA_BITS;
  logic [3:0]    head_rd, sel_rd, rd_d, rd_q;
  logic [LW-1:0] head_data, sel_data, data_d, data_q;
  logic          full, empty, push, pop, we_d, we_q;
  wb_src_e       sel;
  // reset gates ready so no handshake completes while the block is held
  assign lsu_ready = reset & enable & ~full;
  assign push      = lsu_valid & lsu_ready;
  assign sel       = !enable ? WB_NONE : alu_valid ? WB_ALU : !empty ? WB_LSU : WB_NONE;
  assign pop       = sel == WB_LSU;
  assign sel_rd    = sel == WB_ALU ? alu_rd : head_rd;
  assign sel_data  = sel == WB_ALU ? alu_data : head_data;
  assign we_d      = sel != WB_NONE && !is_ro(sel_rd);
  assign rd_d      = we_d ? sel_rd : rd_q;
  assign data_d    = we_d ? sel_data : data_q;
  wb_fifo #(.WIDTH(4 + LW), .DEPTH(LSU_FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({lsu_rd, lsu_data}),
    .rdata ({head_rd, head_data}),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  assign decoded_reg_write_enable = we_q;
  assign decoded_rd_address       = rd_q;
  assign reg_write_data           = data_q;
`ifdef WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] pending_q, pending_d;
  // set is applied after clear so a same-edge issue of the returning rd wins
  always_comb begin
    pending_d = pending_q;
    if (pop) pending_d[head_rd] = 1'b0;
    if (enable && issue_load_valid && !is_ro(issue_load_rd)) pending_d[issue_load_rd] = 1'b1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) pending_q <= '0;
    else pending_q <= pending_d;
  assign hazard = pending_q[check_rs] | pending_q[check_rt] | pending_q[check_rd];
`else
  logic unused_sb;
  assign unused_sb = ^{issue_load_valid, issue_load_rd, check_rs, check_rt, check_rd};
  assign hazard    = 1'b0;
`endif
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed and random stimulus checked against a queue-based reference model.
module tb_reg_writeback;
  localparam int DEPTH = 4;
  logic        clk = 1'b0, reset = 1'b0, enable = 1'b0;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0, issue_load_valid = 1'b0;
  logic [3:0]  alu_rd = '0, lsu_rd = '0, issue_load_rd = '0;
  logic [3:0]  check_rs = '0, check_rt = '0, check_rd = '0;
  logic [31:0] alu_data = '0, lsu_data = '0;
  logic        lsu_ready, hazard, decoded_reg_write_enable;
  logic [3:0]  decoded_rd_address;
  logic [31:0] reg_write_data;
  int checks = 0, failures = 0;
  typedef struct {logic [3:0] rd; logic [31:0] d;} ent_t;
  ent_t        q[$];
  bit          pend[16];
  bit          exp_we;
  logic [3:0]  exp_rd;
  logic [31:0] exp_data;

  reg_writeback dut (
    .clk(clk), .reset(reset), .enable(enable),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_load_valid(issue_load_valid), .issue_load_rd(issue_load_rd),
    .check_rs(check_rs), .check_rt(check_rt), .check_rd(check_rd),
    .hazard(hazard), .decoded_reg_write_enable(decoded_reg_write_enable),
    .decoded_rd_address(decoded_rd_address), .reg_write_data(reg_write_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_hazard();
`ifdef WB_SCOREBOARD_EN
    return pend[check_rs] | pend[check_rt] | pend[check_rd];
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_reset();
    q.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    exp_we = 1'b0;
    exp_rd = '0;
    exp_data = '0;
  endfunction

  task automatic step(input bit en, input bit av, input logic [3:0] ard, input logic [31:0] ad,
                      input bit lv, input logic [3:0] lrd, input logic [31:0] ld,
                      input bit iv, input logic [3:0] ird);
    bit   rdy, wr;
    ent_t w;
    enable = en; alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    issue_load_valid = iv; issue_load_rd = ird;
    #1;
    rdy = en && q.size() < DEPTH;
    chk("lsu_ready", 32'(lsu_ready), 32'(rdy));
    chk("hazard", 32'(hazard), 32'(exp_hazard()));
    @(posedge clk); #1;
    wr = 1'b0;
    if (en) begin
      if (av) begin
        wr = 1'b1; w.rd = ard; w.d = ad;
      end else if (q.size() > 0) begin
        wr = 1'b1; w = q.pop_front(); pend[w.rd] = 1'b0;
      end
      if (lv && rdy) q.push_back('{lrd, ld});
      if (iv && ird < 13) pend[ird] = 1'b1;
    end
    exp_we = wr && w.rd < 13;
    if (exp_we) begin
      exp_rd = w.rd; exp_data = w.d;
    end
    chk("write_enable", 32'(decoded_reg_write_enable), 32'(exp_we));
    chk("rd_address", 32'(decoded_rd_address), 32'(exp_rd));
    chk("write_data", reg_write_data, exp_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset_we", 32'(decoded_reg_write_enable), 32'd0);
    chk("reset_ready", 32'(lsu_ready), 32'd0);
    chk("reset_data", reg_write_data, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    // ALU only: one-cycle latency, single-cycle strobe
    step(1, 1, 4'd3, 32'h04030201, 0, 0, 0, 0, 0);
    chk("alu_only_we", 32'(decoded_reg_write_enable), 32'd1);
    chk("alu_only_data", reg_write_data, 32'h04030201);
    idle(1);
    chk("alu_only_drop", 32'(decoded_reg_write_enable), 32'd0);
    chk("alu_only_hold", reg_write_data, 32'h04030201);
    // contention: ALU wins, loads drain afterwards in order
    for (int i = 0; i < 3; i++) step(1, 1, 4'(1 + i), 32'h100 + i, 1, 4'd5, 32'hAAAAAA00 + i, 0, 0);
    idle(1);
    chk("contention_first_lsu", reg_write_data, 32'hAAAAAA00);
    idle(3);
    // full: ALU busy with loads held
    for (int i = 0; i < 6; i++) step(1, 1, 4'd1, 32'(i), 1, 4'(8 + i), 32'hB0 + i, 0, 0);
    chk("full_ready_drop", 32'(lsu_ready), 32'd0);
    idle(6);
    // scoreboard round trip
    check_rs = 4'd7;
    step(1, 0, 0, 0, 0, 0, 0, 1, 4'd7);
    idle(1);
    step(1, 0, 0, 0, 1, 4'd7, 32'hC7, 0, 0);
    idle(3);
    // read-only destinations are consumed without a write
    step(1, 0, 0, 0, 1, 4'd14, 32'hDEAD, 0, 0);
    idle(2);
    step(1, 1, 4'd13, 32'hBEEF, 0, 0, 0, 0, 0);
    chk("ro_alu_we", 32'(decoded_reg_write_enable), 32'd0);
    // enable low freezes everything
    step(1, 1, 4'd2, 32'h55, 1, 4'd4, 32'h44, 0, 0);
    step(0, 1, 4'd6, 32'h66, 1, 4'd4, 32'h45, 1, 4'd3);
    idle(2);
    // async reset with buffered loads and a pending register
    check_rs = 4'd2;
    step(1, 0, 0, 0, 0, 0, 0, 1, 4'd2);
    for (int i = 0; i < 3; i++) step(1, 1, 4'd9, 32'(i), 1, 4'(1 + i), 32'hE0 + i, 0, 0);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_we", 32'(decoded_reg_write_enable), 32'd0);
    chk("async_rd", 32'(decoded_rd_address), 32'd0);
    chk("async_data", reg_write_data, 32'd0);
    chk("async_ready", 32'(lsu_ready), 32'd0);
    chk("async_hazard", 32'(hazard), 32'd0);
    #1 reset = 1'b1;
    idle(2);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      check_rs = 4'($urandom_range(0, 15));
      check_rt = 4'($urandom_range(0, 15));
      check_rd = 4'($urandom_range(0, 15));
      step($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)));
    end
    idle(6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Parameter THREADS_PER_BLOCK, default 4: number of thread lanes written per writeback.
REQ-002 Parameter DATA_BITS, default 8: width of one lane.
REQ-003 Parameter LSU_FIFO_DEPTH, default 4, power of two >=2: load-return buffer entries.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low (asserted at 0).
REQ-006 enable  input  1  core active; low freezes the block.
REQ-007 alu_valid  input  1  ALU result present this cycle; no backpressure.
REQ-008 alu_rd  input  4  ALU destination register.
REQ-009 alu_data  input  THREADS_PER_BLOCK*DATA_BITS  per-lane ALU results, lane 0 in LSBs.
REQ-010 lsu_valid / lsu_ready  input / output  1 / 1  load-return handshake; transfer when both high.
REQ-011 lsu_rd / lsu_data  input  4 / THREADS_PER_BLOCK*DATA_BITS  load destination and per-lane data.
REQ-012 issue_load_valid / issue_load_rd  input  1 / 4  load issued this cycle, marks rd pending.
REQ-013 check_rs, check_rt, check_rd  input  4 each  source/destination of the instruction awaiting issue.
REQ-014 hazard  output  1  combinational: any checked register pending.
REQ-015 decoded_reg_write_enable  output  1  register-file write strobe, registered.
REQ-016 decoded_rd_address  output  4  write address, registered.
REQ-017 reg_write_data  output  THREADS_PER_BLOCK*DATA_BITS  lane data broadcast to per-thread register files, registered.

Function
REQ-018 Each edge with enable=1 the write stage SHALL select: alu_valid -> ALU; else FIFO non-empty -> FIFO head (popped); else no write.
REQ-019 ALU result presented in cycle N SHALL appear on write outputs after edge N+1 (latency 1).
REQ-020 LSU return accepted at edge E SHALL be pushed to the FIFO and SHALL reach the outputs no earlier than after edge E+1 (latency >=2); FIFO order preserved.
REQ-021 lsu_ready SHALL equal enable AND FIFO not full; a pop in the same cycle SHALL NOT raise lsu_ready when full.
REQ-022 Simultaneous push and pop SHALL keep occupancy unchanged; pointers wrap modulo LSU_FIFO_DEPTH.
REQ-023 A selected entry with rd >= 13 SHALL produce decoded_reg_write_enable=0 (read-only registers) but SHALL still be consumed.
REQ-024 decoded_reg_write_enable SHALL be high for exactly one cycle per write; address/data hold their last values when it is low.
REQ-025 Scoreboard: issue_load_valid with issue_load_rd < 13 SHALL set pending[rd] at the edge; rd >= 13 SHALL be ignored.
REQ-026 pending[rd] SHALL clear at the edge where a FIFO entry for that rd is selected; set and clear of the same rd in one edge -> set wins.
REQ-027 hazard SHALL be 1 iff pending[check_rs] or pending[check_rt] or pending[check_rd]; registers >= 13 never pending.
REQ-028 enable=0 SHALL freeze FIFO, scoreboard and selection, force lsu_ready=0 and decoded_reg_write_enable=0 at the next edge; alu_valid ignored.

Reset
REQ-029 reset=0 SHALL immediately clear FIFO (empty), all pending bits, decoded_reg_write_enable, decoded_rd_address, reg_write_data to 0; lsu_ready=0, hazard=0.
REQ-030 Reset mid-operation SHALL discard buffered loads; the pipeline re-issues after release.

Configuration
REQ-031 With WB_SCOREBOARD_EN defined: scoreboard per REQ-025..027 present.
REQ-032 Without WB_SCOREBOARD_EN: no pending state, hazard tied 0, issue_load_* and check_* unused; writeback unchanged.

Structure
REQ-033 Package gpu_wb_pkg SHALL hold NUM_REGS=16, REG_RO_BASE=13, and enum wb_src_e {WB_NONE, WB_ALU, WB_LSU}.
REQ-034 FIFO SHALL be sub-module wb_fifo (parameterised width/depth, push/pop/full/empty).

Verification
REQ-035 ALU only: alu_valid=1, alu_rd=3, alu_data=0x04030201 at cycle 0 -> write_enable=1, rd=3, data=0x04030201 in cycle 1 only.
REQ-036 Contention: alu_valid and lsu_valid (rd=5, 0xAA..) every cycle for 3 cycles, then ALU idle -> ALU writes cycles 1-3, LSU rd=5 writes cycles 4-6 in order.
REQ-037 Full: lsu_valid held, ALU busy -> lsu_ready drops after 4 accepts; releases one per cycle once ALU idles; no loss or duplication.
REQ-038 Scoreboard: issue load rd=7; check_rs=7 -> hazard=1; load return rd=7 -> hazard=0 the cycle after its write.
REQ-039 Read-only: lsu_rd=14 return -> entry consumed, write_enable stays 0; ALU rd=13 likewise.
REQ-040 Async reset with 3 entries buffered and pending[2]=1 -> outputs 0, FIFO empty, hazard=0 without clock edge.
